// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end. It keeps at most one
// cache request in flight, does static next-PC prediction (JAL always
// taken, conditional branches from the predictor) and buffers fetched
// instructions in a small circular queue that the dispatcher drains.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall)
//   fu_to_ic_*  : fetch request to the instruction cache
//   ic_to_fu_*  : one-cycle response pulse with the instruction word
//   fu_to_bp_*  : predictor query (current PC and returned word)
//   bp_to_fu_prediction : combinational taken/not-taken answer
//   fu_to_dp_*  : queue head towards dispatch, dp_to_fu_ready pops it
//   rob_to_fu_* : redirect pulse and target PC
module inst_fetch_unit #(
    parameter int          IQ_WIDTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic        fu_to_ic_valid,
    output logic [31:0] fu_to_ic_pc,
    input  logic        ic_to_fu_ready,
    input  logic [31:0] ic_to_fu_inst,

    output logic [31:0] fu_to_bp_pc,
    output logic [31:0] fu_to_bp_inst,
    input  logic        bp_to_fu_prediction,

    output logic        fu_to_dp_valid,
    output logic [31:0] fu_to_dp_inst,
    output logic [31:0] fu_to_dp_pc,
    output logic        fu_to_dp_pred,
    input  logic        dp_to_fu_ready,

    input  logic        rob_to_fu_flush,
    input  logic [31:0] rob_to_fu_target_pc
);

    localparam int IQ_SIZE = 2 ** IQ_WIDTH;
    localparam logic [IQ_WIDTH:0]   IQ_FULL = (IQ_WIDTH + 1)'(IQ_SIZE);
    localparam logic [IQ_WIDTH:0]   CNT_ONE = (IQ_WIDTH + 1)'(1);
    localparam logic [IQ_WIDTH-1:0] PTR_ONE = IQ_WIDTH'(1);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    state_e              state_q,    state_d;
    logic [31:0]         pc_q,       pc_d;
    logic                ic_valid_q, ic_valid_d;
    logic [IQ_WIDTH-1:0] head_q,     head_d;
    logic [IQ_WIDTH-1:0] tail_q,     tail_d;
    logic [IQ_WIDTH:0]   count_q,    count_d;
    iq_entry_t           iq_q [IQ_SIZE];
    iq_entry_t           iq_d [IQ_SIZE];

    // ------------------------------------------------------------
    // Next-PC prediction for the word currently returned by the cache
    // ------------------------------------------------------------
    logic [6:0]  opcode;
    logic        is_jal;
    logic        is_branch;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] next_pc;
    logic        next_pred;

    always_comb begin
        opcode    = ic_to_fu_inst[6:0];
        is_jal    = (opcode == OP_JAL);
        is_branch = (opcode == OP_BRANCH);

        j_imm = {{12{ic_to_fu_inst[31]}},
                 ic_to_fu_inst[19:12],
                 ic_to_fu_inst[20],
                 ic_to_fu_inst[30:21],
                 1'b0};

        b_imm = {{20{ic_to_fu_inst[31]}},
                 ic_to_fu_inst[7],
                 ic_to_fu_inst[30:25],
                 ic_to_fu_inst[11:8],
                 1'b0};

        next_pc   = pc_q + 32'd4;
        next_pred = 1'b0;

        // JALR falls into the default: its target depends on a
        // register value, so fetch simply continues sequentially.
        unique case (1'b1)
            is_jal: begin
                next_pc = pc_q + j_imm;
            end
            is_branch: begin
                next_pred = bp_to_fu_prediction;
                next_pc   = bp_to_fu_prediction ? (pc_q + b_imm)
                                                : (pc_q + 32'd4);
            end
            default: begin
                next_pc   = pc_q + 32'd4;
                next_pred = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Queue handshakes
    // ------------------------------------------------------------
    logic iq_empty;
    logic push;
    logic pop;

    always_comb begin
        iq_empty = (count_q == '0);
        // A request is only issued when there is room, so a response
        // in WAIT can always be stored.
        push     = (state_q == S_WAIT) && ic_to_fu_ready;
        pop      = !iq_empty && dp_to_fu_ready;
    end

    // ------------------------------------------------------------
    // FSM next state, pc and queue updates
    // ------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ic_valid_d = ic_valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        iq_d       = iq_q;

        if (rdy_in) begin
            if (rob_to_fu_flush) begin
                // Redirect wins over everything, including a response
                // arriving this cycle; dropping valid makes the cache
                // abandon the old request.
                state_d    = S_IDLE;
                ic_valid_d = 1'b0;
                pc_d       = rob_to_fu_target_pc;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (count_q < IQ_FULL) begin
                            state_d    = S_WAIT;
                            ic_valid_d = 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (ic_to_fu_ready) begin
                            state_d    = S_IDLE;
                            ic_valid_d = 1'b0;
                            pc_d       = next_pc;
                        end
                    end
                endcase

                if (push) begin
                    iq_d[tail_q] = '{inst: ic_to_fu_inst,
                                     pc:   pc_q,
                                     pred: next_pred};
                    tail_d = tail_q + PTR_ONE;
                end

                if (pop) begin
                    head_d = head_q + PTR_ONE;
                end

                unique case ({push, pop})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ic_valid_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                iq_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ic_valid_q <= ic_valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            for (int i = 0; i < IQ_SIZE; i++) begin
                iq_q[i] <= iq_d[i];
            end
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    always_comb begin
        fu_to_ic_valid = ic_valid_q;
        fu_to_ic_pc    = pc_q;

        fu_to_bp_pc    = pc_q;
        fu_to_bp_inst  = ic_to_fu_inst;

        fu_to_dp_valid = !iq_empty;
        fu_to_dp_inst  = iq_q[head_q].inst;
        fu_to_dp_pc    = iq_q[head_q].pc;
        fu_to_dp_pred  = iq_q[head_q].pred;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios followed by a randomized run
// against a queue-based reference model of the fetch unit.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        ic_valid;
    logic [31:0] ic_pc;
    logic        ic_ready;
    logic [31:0] ic_inst;
    logic [31:0] bp_pc;
    logic [31:0] bp_inst;
    logic        bp_pred;
    logic        dp_valid;
    logic [31:0] dp_inst;
    logic [31:0] dp_pc;
    logic        dp_pred;
    logic        dp_ready;
    logic        flush;
    logic [31:0] target;

    int n_checks = 0;
    int n_pass   = 0;

    inst_fetch_unit #(
        .IQ_WIDTH (2),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk_in              (clk),
        .rst_in              (rst_n),
        .rdy_in              (rdy),
        .fu_to_ic_valid      (ic_valid),
        .fu_to_ic_pc         (ic_pc),
        .ic_to_fu_ready      (ic_ready),
        .ic_to_fu_inst       (ic_inst),
        .fu_to_bp_pc         (bp_pc),
        .fu_to_bp_inst       (bp_inst),
        .bp_to_fu_prediction (bp_pred),
        .fu_to_dp_valid      (dp_valid),
        .fu_to_dp_inst       (dp_inst),
        .fu_to_dp_pc         (dp_pc),
        .fu_to_dp_pred       (dp_pred),
        .dp_to_fu_ready      (dp_ready),
        .rob_to_fu_flush     (flush),
        .rob_to_fu_target_pc (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    logic        m_req;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic respond(input logic [31:0] w, input logic p);
        ic_inst  = w;
        bp_pred  = p;
        ic_ready = 1'b1;
        step();
        ic_ready = 1'b0;
    endtask

    // Redirect, then one more cycle so the new request is outstanding.
    task automatic flush_to(input logic [31:0] t);
        flush  = 1'b1;
        target = t;
        step();
        flush  = 1'b0;
        step();
    endtask

    // Branch offset: imm[12|10:5|4:1|11] built with plain arithmetic.
    function automatic logic [31:0] b_off(input logic [31:0] i);
        logic [31:0] v;
        v = 32'(i[11:8]) * 2 + 32'(i[30:25]) * 32 + 32'(i[7]) * 2048;
        if (i[31]) v = v - 32'd4096;
        return v;
    endfunction

    // Jump offset: imm[20|10:1|11|19:12].
    function automatic logic [31:0] j_off(input logic [31:0] i);
        logic [31:0] v;
        v = 32'(i[30:21]) * 2 + 32'(i[20]) * 2048
          + 32'(i[19:12]) * 4096;
        if (i[31]) v = v - 32'h0010_0000;
        return v;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       op = 7'b1100011;
            1:       op = 7'b1101111;
            2:       op = 7'b1100111;
            default: op = 7'b0010011;
        endcase
        return {r[31:7], op};
    endfunction

    initial begin
        int          n;
        int          sz;
        ent_t        e;
        logic [31:0] npc;

        rst_n    = 1'b0;
        rdy      = 1'b1;
        ic_ready = 1'b0;
        ic_inst  = '0;
        bp_pred  = 1'b0;
        dp_ready = 1'b0;
        flush    = 1'b0;
        target   = '0;

        // Reset state
        #2;
        check("rst_ic_valid", 32'(ic_valid), 32'd0);
        check("rst_dp_valid", 32'(dp_valid), 32'd0);
        check("rst_ic_pc", ic_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("first_req_valid", 32'(ic_valid), 32'd1);
        check("first_req_pc", ic_pc, 32'h0);

        // Sequential fetch
        respond(32'h0000_0013, 1'b0);
        check("seq_ic_valid", 32'(ic_valid), 32'd0);
        check("seq_dp_valid", 32'(dp_valid), 32'd1);
        check("seq_dp_inst", dp_inst, 32'h0000_0013);
        check("seq_dp_pc", dp_pc, 32'h0);
        check("seq_dp_pred", 32'(dp_pred), 32'd0);
        step();
        check("seq_next_valid", 32'(ic_valid), 32'd1);
        check("seq_next_pc", ic_pc, 32'h4);

        // Backward branch, predicted taken
        flush_to(32'h100);
        ic_inst  = 32'hFE00_0EE3;
        bp_pred  = 1'b1;
        ic_ready = 1'b1;
        #1;
        check("bp_pc", bp_pc, 32'h100);
        check("bp_inst", bp_inst, 32'hFE00_0EE3);
        step();
        ic_ready = 1'b0;
        check("br_t_pred", 32'(dp_pred), 32'd1);
        check("br_t_pc", dp_pc, 32'h100);
        step();
        check("br_t_next_pc", ic_pc, 32'hFC);

        // Same branch, predicted not taken
        flush_to(32'h100);
        respond(32'hFE00_0EE3, 1'b0);
        check("br_nt_pred", 32'(dp_pred), 32'd0);
        step();
        check("br_nt_next_pc", ic_pc, 32'h104);

        // JAL ignores the predictor
        flush_to(32'h20);
        respond(32'h0080_006F, 1'b1);
        check("jal_pred", 32'(dp_pred), 32'd0);
        check("jal_inst", dp_inst, 32'h0080_006F);
        step();
        check("jal_next_pc", ic_pc, 32'h28);

        // Fill the queue while dispatch is stalled
        flush_to(32'h0);
        dp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (ic_valid) begin
                respond(32'h0000_0013, 1'b0);
                n++;
            end else begin
                step();
            end
        end
        check("full_entries", 32'(n), 32'd4);
        check("full_ic_valid", 32'(ic_valid), 32'd0);
        check("full_dp_valid", 32'(dp_valid), 32'd1);
        check("full_head_pc", dp_pc, 32'h0);
        dp_ready = 1'b1;
        step();
        dp_ready = 1'b0;
        check("pop_head_pc", dp_pc, 32'h4);
        step();
        check("pop_req_valid", 32'(ic_valid), 32'd1);
        check("pop_req_pc", ic_pc, 32'h10);

        // Flush colliding with a response
        ic_inst  = 32'h0000_0013;
        ic_ready = 1'b1;
        flush    = 1'b1;
        target   = 32'h400;
        step();
        ic_ready = 1'b0;
        flush    = 1'b0;
        check("flush_dp_valid", 32'(dp_valid), 32'd0);
        check("flush_ic_valid", 32'(ic_valid), 32'd0);
        step();
        check("flush_req_valid", 32'(ic_valid), 32'd1);
        check("flush_req_pc", ic_pc, 32'h400);

        // Global stall during WAIT
        rdy      = 1'b0;
        ic_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_ic_valid", 32'(ic_valid), 32'd1);
            check("stall_ic_pc", ic_pc, 32'h400);
            check("stall_dp_valid", 32'(dp_valid), 32'd0);
        end
        rdy      = 1'b1;
        ic_ready = 1'b0;
        step();
        check("unstall_ic_valid", 32'(ic_valid), 32'd1);
        check("unstall_ic_pc", ic_pc, 32'h400);
        check("unstall_dp_valid", 32'(dp_valid), 32'd0);

        // Randomized run against the reference model
        flush_to(32'h1000);
        mq.delete();
        mpc   = 32'h1000;
        m_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_ic_valid", 32'(ic_valid), 32'(m_req));
            if (m_req) begin
                check("rnd_ic_pc", ic_pc, mpc);
                check("rnd_bp_pc", bp_pc, mpc);
            end
            check("rnd_dp_valid", 32'(dp_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("rnd_dp_inst", dp_inst, mq[0].inst);
                check("rnd_dp_pc", dp_pc, mq[0].pc);
                check("rnd_dp_pred", 32'(dp_pred), 32'(mq[0].pred));
            end

            rdy      = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            target   = $urandom & 32'hFFFF_FFFC;
            ic_ready = m_req && ($urandom_range(0, 2) == 0);
            ic_inst  = gen_inst();
            bp_pred  = 1'($urandom_range(0, 1));
            dp_ready = 1'($urandom_range(0, 1));

            if (rdy) begin
                if (flush) begin
                    mq.delete();
                    mpc   = target;
                    m_req = 1'b0;
                end else begin
                    sz = mq.size();
                    if (sz != 0 && dp_ready) void'(mq.pop_front());
                    if (m_req) begin
                        if (ic_ready) begin
                            e.inst = ic_inst;
                            e.pc   = mpc;
                            e.pred = 1'b0;
                            npc    = mpc + 32'd4;
                            if (ic_inst[6:0] == 7'b1101111) begin
                                npc = mpc + j_off(ic_inst);
                            end else if (ic_inst[6:0] == 7'b1100011) begin
                                e.pred = bp_pred;
                                if (bp_pred) npc = mpc + b_off(ic_inst);
                            end
                            mq.push_back(e);
                            mpc   = npc;
                            m_req = 1'b0;
                        end
                    end else begin
                        m_req = (sz < 4);
                    end
                end
            end
            step();
        end

        // Asynchronous reset in the middle of WAIT with a queued entry
        rdy      = 1'b1;
        flush    = 1'b0;
        ic_ready = 1'b0;
        dp_ready = 1'b0;
        flush_to(32'h800);
        respond(32'h0000_0013, 1'b0);
        step();
        check("pre_rst_ic_valid", 32'(ic_valid), 32'd1);
        check("pre_rst_dp_valid", 32'(dp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ic_valid", 32'(ic_valid), 32'd0);
        check("async_rst_dp_valid", 32'(dp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rerst_req_valid", 32'(ic_valid), 32'd1);
        check("rerst_req_pc", ic_pc, 32'h0);
        check("rerst_dp_valid", 32'(dp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
